instruction_fetch: RTL and testbench

//   Initiator side of the instruction-memory port: holds the PC, drives io_imem_addr, captures io_imem_data
//   (1-cycle synchronous read latency), buffers fetched words with their PC and hands them to decode over a

---
 rtl/rv_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch slice.
// Revision : 1.0 - initial release
// ============================================================================
package rv_fetch_pkg;

    localparam int              XLEN       = 32;
    localparam int              INST_BYTES = 4;
    localparam logic [XLEN-1:0] INST_NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two FIFO of fetch entries with push/pop/flush and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = DEPTH[c_AW:0];

    fetch_entry_t      r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC generation, 1-cycle imem request tracking, fetch buffer and
//            redirect handling. IFETCH_MISALIGN_TRAP_EN enables misalign traps.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] io_imem_addr,
    input  logic [XLEN-1:0] io_imem_data,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_pc,
    output logic            io_inst_valid,
    input  logic            io_inst_ready,
    output logic [XLEN-1:0] io_inst,
    output logic [XLEN-1:0] io_inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic            io_inst_misalign
`endif
);

    localparam int                 c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_OCC = FIFO_DEPTH[c_CNT_W:0];
    localparam logic [XLEN-1:0]    c_PC_STEP   = INST_BYTES;

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_req_pc;
    logic               r_inflight;

    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W:0]   w_occ;
    logic               w_head_live;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic               w_stall;
    logic               w_trap_push;
    logic [XLEN-1:0]    w_redirect_pc;

    // Buffer occupancy counts the response already in flight from memory.
    assign w_occ   = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_valid = w_head_live && !io_redirect_valid;
    assign w_pop   = w_valid && io_inst_ready;
    assign w_issue = !io_redirect_valid && !w_stall &&
                     ((w_occ < c_DEPTH_OCC) || ((w_occ == c_DEPTH_OCC) && w_pop));
    assign w_push  = (r_inflight && !io_redirect_valid) || w_trap_push;

    always_comb begin
        w_push_entry = '{inst: io_imem_data, pc: r_req_pc, misalign: 1'b0};
        if (w_trap_push) begin
            w_push_entry = '{inst: INST_NOP, pc: r_fetch_pc, misalign: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (io_redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_trap_stall;
    logic r_trap_pend;

    // A misaligned target parks fetch; the trap entry is emitted the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trap_stall <= 1'b0;
            r_trap_pend  <= 1'b0;
        end else if (io_redirect_valid) begin
            r_trap_stall <= |io_redirect_pc[1:0];
            r_trap_pend  <= |io_redirect_pc[1:0];
        end else begin
            r_trap_pend  <= 1'b0;
        end
    end

    assign w_stall          = r_trap_stall;
    assign w_trap_push      = r_trap_pend;
    assign w_redirect_pc    = io_redirect_pc;
    assign w_head_live      = !w_empty;
    assign io_inst_misalign = w_head_live && w_head.misalign;
`else
    assign w_stall       = 1'b0;
    assign w_trap_push   = 1'b0;
    assign w_redirect_pc = io_redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    // Trap entries are never produced in this build.
    assign w_head_live   = !w_empty && !w_head.misalign;
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (io_redirect_valid),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign io_imem_addr  = r_fetch_pc;
    assign io_inst_valid = w_valid;
    assign io_inst       = w_head_live ? w_head.inst : '0;
    assign io_inst_pc    = w_head_live ? w_head.pc   : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench: directed steps plus random ready/redirects
//            scored against an in-order PC stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_KEY  = 32'h5A5A_C3C3;
    localparam logic [31:0] c_WRAP = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [31:0] w_addr, w_data, w_inst, w_pc;
    logic        w_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        inst_misalign, w_misalign;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .io_imem_addr(imem_addr), .io_imem_data(imem_data),
        .io_redirect_valid(redirect_valid), .io_redirect_pc(redirect_pc),
        .io_inst_valid(inst_valid), .io_inst_ready(inst_ready),
        .io_inst(inst), .io_inst_pc(inst_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
        , .io_inst_misalign(inst_misalign)
`endif
    );

    instruction_fetch #(.RESET_PC(c_WRAP), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset), .io_imem_addr(w_addr), .io_imem_data(w_data),
        .io_redirect_valid(1'b0), .io_redirect_pc(32'h0),
        .io_inst_valid(w_valid), .io_inst_ready(1'b1),
        .io_inst(w_inst), .io_inst_pc(w_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
        , .io_inst_misalign(w_misalign)
`endif
    );

    // Instruction memories: one-cycle read, word content derived from its address.
    always @(posedge clk) imem_data <= imem_addr ^ c_KEY;
    always @(posedge clk) w_data    <= w_addr ^ c_KEY;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_xfer = 0;
    int          w_cyc = 0;
    logic [31:0] exp_pc, w_exp;
    bit          hold_pending;
    logic [31:0] hold_inst, hold_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then score outputs.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (hold_pending && !rv) begin
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
            check("hold_inst", inst, hold_inst);
            check("hold_pc", inst_pc, hold_pc);
        end
        if (rv) begin
            check("redirect_no_valid", {31'b0, inst_valid}, 32'd0);
        end else if (inst_valid && rdy) begin
            check("xfer_pc", inst_pc, exp_pc);
            check("xfer_inst", inst, exp_pc ^ c_KEY);
`ifdef IFETCH_MISALIGN_TRAP_EN
            check("xfer_misalign", {31'b0, inst_misalign}, 32'd0);
`endif
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        hold_pending = inst_valid && !rdy && !rv;
        hold_inst    = inst;
        hold_pc      = inst_pc;
        if (rv) exp_pc = rpc & 32'hFFFF_FFFC;
        check("wrap_valid", {31'b0, w_valid}, {31'b0, (w_cyc >= 1)});
        if (w_valid) begin
            check("wrap_pc", w_pc, w_exp);
            check("wrap_inst", w_inst, w_exp ^ c_KEY);
            w_exp = w_exp + 32'd4;
        end
        w_cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          x0;
        bit          found;
        logic [31:0] rpc;

        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        hold_pending = 1'b0; exp_pc = 32'h0; w_exp = c_WRAP;
        @(negedge clk); @(negedge clk);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_addr, c_WRAP);
        reset = 1'b0;
        #1 check("first_addr", imem_addr, 32'h0);

        // Startup and decode back-pressure right after the first valid.
        cycle(1, 0, 0);
        check("t1_valid0", {31'b0, inst_valid}, 32'd0);
        check("t1_addr4", imem_addr, 32'h4);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0);
            check("t2_addr_stall", imem_addr, 32'h8);
            check("t2_pc_frozen", inst_pc, 32'h0);
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0);
            check("t2_throughput", {31'b0, inst_valid}, 32'd1);
        end

        // Redirect with a full buffer.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(0, 1, 32'h100);
        cycle(1, 0, 0);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_valid_r1", {31'b0, inst_valid}, 32'd0);
        cycle(1, 0, 0);
        check("t3_valid_r2", {31'b0, inst_valid}, 32'd0);
        cycle(1, 0, 0);
        check("t3_valid_r3", {31'b0, inst_valid}, 32'd1);
        check("t3_pc", inst_pc, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Back-to-back redirects: the later target wins.
        cycle(1, 1, 32'h200);
        cycle(1, 1, 32'h300);
        cycle(1, 0, 0);
        check("t4_addr", imem_addr, 32'h300);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("t4_valid", {31'b0, inst_valid}, 32'd1);
        check("t4_pc", inst_pc, 32'h300);

        // Random back-pressure and redirects.
        x0 = n_xfer;
        for (int i = 0; i < 300; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rpc & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        check("rand_progress", {31'b0, ((n_xfer - x0) > 60)}, 32'd1);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, inst_valid}, 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_wrap_addr", w_addr, c_WRAP);
        #1 reset = 1'b0;
        exp_pc = 32'h0; w_exp = c_WRAP; w_cyc = 0; hold_pending = 1'b0;
        cycle(1, 0, 0);
        check("arst_addr4", imem_addr, 32'h4);
        check("arst_valid1", {31'b0, inst_valid}, 32'd0);
        cycle(1, 0, 0);
        check("arst_restart_pc", inst_pc, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Misaligned redirect target.
        cycle(1, 1, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            inst_ready = 1'b1; redirect_valid = 1'b0;
            #1;
            if (inst_valid) begin
                found = 1'b1;
                check("mis_flag", {31'b0, inst_misalign}, 32'd1);
                check("mis_inst", inst, 32'h0000_0013);
                check("mis_pc", inst_pc, 32'h102);
            end
        end
        check("mis_found", {31'b0, found}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check("mis_idle", {31'b0, inst_valid}, 32'd0);
        end
`else
        found = 1'b0;
        cycle(1, 0, 0);
        check("align_addr", imem_addr, 32'h100);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        found = inst_valid;
        check("align_valid", {31'b0, found}, 32'd1);
        check("align_pc", inst_pc, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
